// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = (x - y - b_in) mod 2^N, one bit per
//   clock, LSB first, built from a single full-subtractor cell and a borrow
//   flip-flop. Start/busy/done handshake. The result is held until the next
//   accepted start.
//
// Parameters
//   N      operand/result width in bits (N >= 2)
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, sampled only when not busy (IDLE or DONE)
//   x, y   minuend / subtrahend, latched on the accepting edge
//   b_in   borrow-in, latched on the accepting edge
//   busy   high exactly while in RUN
//   done   one-cycle pulse, diff/b_out (and ovf) are valid
//   diff   (x - y - b_in) mod 2^N
//   b_out  final borrow: 1 iff x < y + b_in (unsigned)
//   ovf    two's-complement overflow, only when SERIAL_SUB_OVF_EN is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  xs;
  logic [N-1:0]  ys;
  logic          borrow;
  logic [CW-1:0] cnt;

  // Full-subtractor cell operating on the current LSBs.
  logic d;
  logic borrow_nxt;

  always_comb begin
    d          = xs[0] ^ ys[0] ^ borrow;
    borrow_nxt = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & borrow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      xs     <= '0;
      ys     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a start exactly like IDLE so back-to-back issue works.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xs     <= x;
            ys     <= y;
            borrow <= b_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          xs     <= xs >> 1;
          ys     <= ys >> 1;
          borrow <= borrow_nxt;
          diff   <= {d, diff[N-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            b_out <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // On the last edge xs[0]/ys[0] are the latched operand MSBs and
            // d is the result MSB, so no extra MSB registers are needed.
            ovf   <= (xs[0] != ys[0]) && (d != xs[0]);
`endif
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
